hap_base_fetch: RTL and testbench
=================================

Name: hap_base_fetch

Overview:
- Read-side consumer of the haplotype SRAM (GATK_Haplotype_SRAM).
- On a start command, reads a haplotype from consecutive SRAM words. Each word is unpacked into individual bases and streamed to the Pair-HMM PE array over a valid/ready interface.
- Absorbs the SRAM's fixed 2-cycle read latency with a small word FIFO, so downstream backpressure never drops or duplicates a base.

Parameters:
- WORD_W, 64, SRAM word width; equals `HAP_SRAM_BIT_PER_WORD.
- ADDR_W, 10, SRAM address width; equals $clog2(`HAP_SRAM_WORD_AMOUNT).
- BASE_W, 8, bits per base (ASCII). WORD_W must be a multiple of BASE_W. BPW = WORD_W/BASE_W.
- LEN_W, 10, haplotype length field width, in bases.
- FIFO_DEPTH, 4, word FIFO entries; power of two, ≥ RD_LAT+1.
- RD_LAT, 2, SRAM read latency in cycles, from address presented to rdata valid.

Ports:
- clk  in  1  system clock; drives the SRAM clka.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle command pulse; ignored while busy=1.
- base_addr  in  ADDR_W  first SRAM word of the haplotype; sampled with start.
- hap_len  in  LEN_W  haplotype length in bases; sampled with start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the fetch completes.
- sram_we  out  1  SRAM write enable; tied 0, this block is read-only.
- sram_addr  out  ADDR_W  SRAM read address.
- sram_rdata  in  WORD_W  SRAM douta.
- out_valid  out  1  out_base is valid.
- out_ready  in  1  downstream accepts the base.
- out_base  out  BASE_W  current base.
- out_last  out  1  marks the final base of the haplotype; qualified by out_valid.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE; FIFO, counters and in-flight pipeline are cleared.
  - busy, done, out_valid, out_last, sram_we = 0; sram_addr, out_base = 0.
  - Reset mid-run abandons the transfer; SRAM reads still in flight are discarded.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start with hap_len ≠ 0. Latches words_left = ceil(hap_len/BPW), bases_left = hap_len, rd_ptr = base_addr.
  - IDLE -> DONE on start with hap_len = 0. No reads issued, no output.
  - RUN -> DONE on the handshake (out_valid & out_ready) of the final base.
  - DONE -> IDLE unconditionally. done = 1 for exactly that one cycle.
- busy = 1 in RUN and DONE. start is ignored while busy=1.
- Read issue:
  - In RUN, issue a read in a cycle when words_left > 0 and (fifo_count + inflight) < FIFO_DEPTH.
  - Issuing a read drives sram_addr = rd_ptr, increments rd_ptr modulo 2^ADDR_W (wrap-around), and decrements words_left.
  - The first read is issued in the cycle after start.
  - sram_addr holds its last value when no read is issued.
- Return path:
  - A RD_LAT-deep valid shift register tags issued reads.
  - The tagged sram_rdata is written into the FIFO RD_LAT cycles after issue.
  - The FIFO never overflows, by construction of the issue rule.
- Unpack:
  - Base k of a word is bits [k*BASE_W +: BASE_W]; k=0 is the LSBs and is emitted first.
  - A base index counter selects the base from the FIFO head word. The word is popped after base BPW-1, or after the final base of the haplotype (partial last word; the unused bases are discarded).
- Output:
  - out_valid = FIFO non-empty in RUN.
  - out_base and out_valid hold stable while out_ready = 0.
  - out_last = out_valid & (bases_left == 1).
  - Full throughput is 1 base/cycle. Reads stall automatically under backpressure.
- Latency: with out_ready = 1, the first out_valid is asserted exactly RD_LAT+2 cycles after the start edge. This is 4 cycles at default parameters.

Test Plan:
- Full throughput: base_addr=5, hap_len=20, out_ready=1.
  - Reads issued at addresses 5, 6, 7 only.
  - 20 bases on 20 consecutive cycles, in LSB-first order from words 5, 6 and 7 (4 bases from word 7).
  - out_last on the 20th base; done one cycle after it; busy falls with done.
- Backpressure: hap_len=64; out_ready toggles 0 for 10 cycles mid-stream and then random at 50%.
  - The output sequence is identical to the full-throughput case.
  - (fifo_count + inflight) never exceeds 4.
  - out_base is stable while stalled.
- Zero length: start with hap_len=0 -> done pulses the next cycle; no sram_addr change; out_valid never asserts.
- Wrap-around: base_addr=1023, hap_len=16 -> reads at 1023 then 0; 16 bases in order; done.
- Exact word / ignored start: hap_len=8 -> one read, out_last on the 8th base. A second start pulsed while busy is ignored: no extra reads and no extra done.
- Reset mid-run: rst_n=0 at the 5th base of hap_len=40.
  - All outputs go to 0 immediately.
  - After release, start with base_addr=0, hap_len=3 completes normally with no stale bases.

Source files
------------

// File: rtl/hap_base_fetch.sv
// Purpose: fetch a haplotype from consecutive SRAM words and stream it out one base per cycle.
// Latency: first out_valid RD_LAT+2 cycles after the start edge; one base per cycle after that.
// Backpressure: out_ready low holds the current base; SRAM reads stop once the word FIFO is committed.

// Purpose: generic word FIFO with valid/ready on both sides.
// Latency: one cycle from push to out_vld; head data is read combinationally.
// Backpressure: pushes are dropped when full, so the producer must track count before pushing.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_vld,
    input  logic [W-1:0]           in_dat,
    output logic                   out_vld,
    input  logic                   out_rdy,
    output logic [W-1:0]           out_dat,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push, pop;

    assign push    = in_vld && (count_q != (PTR_W+1)'(DEPTH));
    assign pop     = out_rdy && (count_q != '0);
    assign out_vld = (count_q != '0);
    assign out_dat = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Pointer and occupancy next-state; pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are only observed through a non-empty head, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_dat;
        end
    end
endmodule

module hap_base_fetch #(
    parameter int WORD_W     = 64,
    parameter int ADDR_W     = 10,
    parameter int BASE_W     = 8,
    parameter int LEN_W      = 10,
    parameter int FIFO_DEPTH = 4,
    parameter int RD_LAT     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  hap_len,
    output logic              busy,
    output logic              done,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [WORD_W-1:0] sram_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BASE_W-1:0] out_base,
    output logic              out_last
);
    localparam int BPW    = WORD_W / BASE_W;
    localparam int IDX_W  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int OCC_W  = $clog2(FIFO_DEPTH + RD_LAT + 1) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  words_left_q, words_left_d;
    logic [LEN_W-1:0]  bases_left_q, bases_left_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic [IDX_W-1:0]  base_idx_q, base_idx_d;
    // Stage 0 marks the cycle the address is on the bus; stage RD_LAT marks valid sram_rdata.
    logic [RD_LAT:0]   tag_q, tag_d;

    logic [LEN_W:0]    len_round;
    logic [LEN_W-1:0]  words_calc;
    logic [OCC_W-1:0]  inflight;
    logic [FCNT_W-1:0] fifo_cnt;
    logic              fifo_vld;
    logic [WORD_W-1:0] head_word;
    logic [BASE_W-1:0] sel_base;
    logic              issue;
    logic              fire;
    logic              pop_word;
    logic              final_base;

    // Word count rounds up so a partial last word is still fetched; one extra bit avoids overflow.
    assign len_round  = {1'b0, hap_len} + (LEN_W+1)'(BPW - 1);
    assign words_calc = LEN_W'(len_round / (LEN_W+1)'(BPW));

    assign final_base = (bases_left_q == LEN_W'(1));
    assign out_valid  = fifo_vld && (state_q == RUN);
    assign fire       = out_valid && out_ready;
    assign pop_word   = fire && ((base_idx_q == IDX_W'(BPW - 1)) || final_base);
    assign out_last   = out_valid && final_base;
    assign out_base   = out_valid ? sel_base : '0;

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign sram_we   = 1'b0;
    assign sram_addr = sram_addr_q;

    // Count reads in flight so the FIFO space they will need is already reserved.
    always_comb begin
        inflight = '0;
        for (int i = 0; i <= RD_LAT; i++) begin
            inflight = inflight + OCC_W'(tag_q[i]);
        end
    end

    assign issue = (state_q == RUN) && (words_left_q != '0) &&
                   ((OCC_W'(fifo_cnt) + inflight) < OCC_W'(FIFO_DEPTH));

    // Pick the current base out of the head word, LSB base first.
    always_comb begin
        sel_base = '0;
        for (int k = 0; k < BPW; k++) begin
            if (base_idx_q == IDX_W'(k)) begin
                sel_base = head_word[k*BASE_W +: BASE_W];
            end
        end
    end

    // Next-state logic: command acceptance, read issue and per-base bookkeeping.
    always_comb begin
        state_d      = state_q;
        words_left_d = words_left_q;
        bases_left_d = bases_left_q;
        rd_ptr_d     = rd_ptr_q;
        sram_addr_d  = sram_addr_q;
        base_idx_d   = base_idx_q;
        tag_d        = {tag_q[RD_LAT-1:0], issue};
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (hap_len == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d      = RUN;
                        words_left_d = words_calc;
                        bases_left_d = hap_len;
                        rd_ptr_d     = base_addr;
                        base_idx_d   = '0;
                    end
                end
            end
            RUN: begin
                if (issue) begin
                    sram_addr_d  = rd_ptr_q;
                    rd_ptr_d     = rd_ptr_q + ADDR_W'(1);
                    words_left_d = words_left_q - LEN_W'(1);
                end
                if (fire) begin
                    bases_left_d = bases_left_q - LEN_W'(1);
                    base_idx_d   = pop_word ? '0 : base_idx_q + IDX_W'(1);
                    if (final_base) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset also flushes the read-tag pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            words_left_q <= '0;
            bases_left_q <= '0;
            rd_ptr_q     <= '0;
            sram_addr_q  <= '0;
            base_idx_q   <= '0;
            tag_q        <= '0;
        end else begin
            state_q      <= state_d;
            words_left_q <= words_left_d;
            bases_left_q <= bases_left_d;
            rd_ptr_q     <= rd_ptr_d;
            sram_addr_q  <= sram_addr_d;
            base_idx_q   <= base_idx_d;
            tag_q        <= tag_d;
        end
    end

    sync_fifo #(
        .W     (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_word_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (tag_q[RD_LAT]),
        .in_dat  (sram_rdata),
        .out_vld (fifo_vld),
        .out_rdy (pop_word),
        .out_dat (head_word),
        .count   (fifo_cnt)
    );
endmodule

// File: tb/tb_hap_base_fetch.sv
// Purpose: scoreboard bench for hap_base_fetch against a behavioural SRAM with RD_LAT delay.
// Latency: expects first base RD_LAT+2 cycles after start and done one cycle after the last base.
// Backpressure: drives out_ready high, held low, or random, and checks the held base stays put.
module tb_hap_base_fetch;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [9:0]  base_addr;
    logic [9:0]  hap_len;
    logic        busy;
    logic        done;
    logic        sram_we;
    logic [9:0]  sram_addr;
    logic [63:0] sram_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_base;
    logic        out_last;

    hap_base_fetch dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .hap_len    (hap_len),
        .busy       (busy),
        .done       (done),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_rdata (sram_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_base   (out_base),
        .out_last   (out_last)
    );

    typedef struct packed {
        logic [7:0] base;
        logic       last;
        logic       wend;
    } exp_t;

    exp_t        exp_q[$];
    logic [9:0]  exp_addr_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          start_cyc, first_cyc, last_cyc, done_cyc;
    int          fire_cnt, reads_seen, words_done, done_cnt, done_base;
    logic        first_armed = 1'b0;
    logic        addr_chk_en = 1'b0;
    logic        occ_chk_en = 1'b0;
    logic        stall_vld = 1'b0;
    logic [7:0]  stall_base;
    logic [9:0]  prev_addr;
    int          rdy_mode = 0;

    logic [63:0] mem [1024];
    logic [9:0]  a1, a2;

    function automatic logic [7:0] pat(input int w, input int k);
        return 8'((w * 7 + k * 29 + 3) % 256);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        for (int a = 0; a < 1024; a++) begin
            for (int k = 0; k < 8; k++) begin
                mem[a][k*8 +: 8] = pat(a, k);
            end
        end
    end

    // Behavioural SRAM: data for an address appears RD_LAT cycles after the address does.
    always @(posedge clk) begin
        a1 <= sram_addr;
        a2 <= a1;
    end
    assign sram_rdata = mem[a2];

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: read addresses, stall stability, scoreboard pops, done pulses.
    initial begin
        exp_t e;
        logic [9:0] ea;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_vld = 1'b0;
                prev_addr = sram_addr;
            end else begin
                if (sram_addr != prev_addr) begin
                    reads_seen++;
                    if (addr_chk_en) begin
                        if (exp_addr_q.size() == 0) begin
                            chk("extra_read", 64'(sram_addr), 64'(prev_addr));
                        end else begin
                            ea = exp_addr_q.pop_front();
                            chk("rd_addr", 64'(sram_addr), 64'(ea));
                        end
                    end
                    prev_addr = sram_addr;
                end
                if (occ_chk_en) begin
                    chk("occupancy_le4", 64'((reads_seen - words_done) <= 4), 64'(1));
                end
                if (stall_vld) begin
                    chk("stall_hold", {out_valid, out_base}, {1'b1, stall_base});
                end
                stall_vld  = out_valid && !out_ready;
                stall_base = out_base;
                if (out_valid && first_armed) begin
                    first_cyc   = cyc;
                    first_armed = 1'b0;
                end
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_valid", 64'(out_valid), 64'(0));
                    end else if (out_ready) begin
                        e = exp_q.pop_front();
                        chk("base", 64'(out_base), 64'(e.base));
                        chk("last", 64'(out_last), 64'(e.last));
                        fire_cnt++;
                        if (e.last) last_cyc = cyc;
                        if (e.wend) words_done++;
                    end
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
            end
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_done"}, 64'(done), 64'(0));
        chk({tag, "_we"}, 64'(sram_we), 64'(0));
        chk({tag, "_addr"}, 64'(sram_addr), 64'(0));
        chk({tag, "_valid"}, 64'(out_valid), 64'(0));
        chk({tag, "_base"}, 64'(out_base), 64'(0));
        chk({tag, "_last"}, 64'(out_last), 64'(0));
    endtask

    task automatic start_fetch(input int addr, input int len);
        exp_t e;
        int nw;
        for (int i = 0; i < len; i++) begin
            e.base = pat((addr + i / 8) % 1024, i % 8);
            e.last = (i == len - 1);
            e.wend = ((i % 8) == 7) || (i == len - 1);
            exp_q.push_back(e);
        end
        nw = (len + 7) / 8;
        for (int j = 0; j < nw; j++) begin
            exp_addr_q.push_back(10'((addr + j) % 1024));
        end
        fire_cnt    = 0;
        reads_seen  = 0;
        words_done  = 0;
        first_cyc   = -1;
        last_cyc    = -1;
        done_cyc    = -1;
        first_armed = 1'b1;
        done_base   = done_cnt;
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = 10'(addr);
        hap_len   = 10'(len);
        @(posedge clk);
        #1;
        start_cyc = cyc;
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int len);
        for (int i = 0; i < 3000; i++) begin
            if (done) break;
            @(posedge clk);
            #1;
        end
        chk({tag, "_done_seen"}, 64'(done), 64'(1));
        chk({tag, "_busy_at_done"}, 64'(busy), 64'(1));
        chk({tag, "_bases_left"}, 64'(exp_q.size()), 64'(0));
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, 64'(done), 64'(0));
        chk({tag, "_busy_after"}, 64'(busy), 64'(0));
        chk({tag, "_done_count"}, 64'(done_cnt - done_base), 64'(1));
        if (addr_chk_en) begin
            chk({tag, "_reads_left"}, 64'(exp_addr_q.size()), 64'(0));
        end
        if (len != 0) begin
            chk({tag, "_latency"}, 64'(first_cyc - start_cyc), 64'(4));
            chk({tag, "_done_after_last"}, 64'(done_cyc - last_cyc), 64'(1));
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        hap_len   = '0;
        done_cnt  = 0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        addr_chk_en = 1'b1;

        // Full throughput: words 5..7, 4 bases from the last one.
        start_fetch(5, 20);
        wait_done("full", 20);

        // Backpressure: solid stall then random ready.
        start_fetch(40, 64);
        occ_chk_en = 1'b1;
        for (int i = 0; i < 500; i++) begin
            if (fire_cnt >= 20) break;
            @(posedge clk);
            #1;
        end
        rdy_mode = 1;
        repeat (10) @(posedge clk);
        rdy_mode = 2;
        wait_done("bp", 64);
        occ_chk_en = 1'b0;
        rdy_mode   = 0;
        repeat (2) @(posedge clk);

        // Zero length: done next cycle, no reads, no output.
        start_fetch(123, 0);
        wait_done("zero", 0);
        chk("zero_done_cyc", 64'(done_cyc - start_cyc), 64'(0));
        chk("zero_no_valid", 64'(first_armed), 64'(1));

        // Address wrap-around.
        start_fetch(1023, 16);
        wait_done("wrap", 16);

        // Exact word with a second start while busy.
        start_fetch(200, 8);
        @(posedge clk);
        #1;
        chk("ign_busy", 64'(busy), 64'(1));
        start     = 1'b1;
        base_addr = 10'd300;
        hap_len   = 10'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("exact", 8);
        repeat (10) @(posedge clk);
        #1;
        chk("ign_no_done", 64'(done_cnt - done_base), 64'(1));
        chk("ign_no_reads", 64'(exp_addr_q.size()), 64'(0));
        chk("ign_idle", 64'(busy), 64'(0));

        // Reset mid-run at the 5th base, then a clean short run.
        addr_chk_en = 1'b0;
        start_fetch(100, 40);
        for (int i = 0; i < 200; i++) begin
            if (fire_cnt >= 4) break;
            @(posedge clk);
            #1;
        end
        chk("rst_fifth_valid", 64'(out_valid), 64'(1));
        chk("rst_fifth_base", 64'(out_base), 64'(pat(100, 4)));
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        exp_q.delete();
        exp_addr_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        start_fetch(0, 3);
        wait_done("post_rst", 3);
        chk("post_rst_bases", 64'(fire_cnt), 64'(3));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
